// File: rtl/rvsteel_bus_arbiter.sv
// rvsteel_bus_arbiter: round-robin sharing of the single system-bus manager port.
// Optional WAIT timeout (and its TIMEOUT_CYCLES parameter) exists only when
// RVSTEEL_BUS_ARBITER_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no owner, every output parked at zero
// ISSUE | owner's request on the bus, bus response still stale and ignored
// WAIT  | owner's request on the bus, completes on the matching response

module rvsteel_bus_arbiter #(
   parameter int NUM_MANAGERS = 2
`ifdef RVSTEEL_BUS_ARBITER_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 255
`endif
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [NUM_MANAGERS*32-1:0]   mgr_rw_address,
   output logic [NUM_MANAGERS*32-1:0]   mgr_read_data,
   input  logic [NUM_MANAGERS-1:0]      mgr_read_request,
   output logic [NUM_MANAGERS-1:0]      mgr_read_response,
   input  logic [NUM_MANAGERS*32-1:0]   mgr_write_data,
   input  logic [NUM_MANAGERS*4-1:0]    mgr_write_strobe,
   input  logic [NUM_MANAGERS-1:0]      mgr_write_request,
   output logic [NUM_MANAGERS-1:0]      mgr_write_response,
   output logic [31:0]                  bus_rw_address,
   input  logic [31:0]                  bus_read_data,
   output logic                         bus_read_request,
   input  logic                         bus_read_response,
   output logic [31:0]                  bus_write_data,
   output logic [3:0]                   bus_write_strobe,
   output logic                         bus_write_request,
   input  logic                         bus_write_response,
   output logic [NUM_MANAGERS-1:0]      grant
`ifdef RVSTEEL_BUS_ARBITER_TIMEOUT_EN
   ,
   output logic                         bus_timeout
`endif
);

   localparam int IDX_W = (NUM_MANAGERS > 1) ? $clog2(NUM_MANAGERS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT
   } state_t;

   state_t              state, state_next;
   logic [IDX_W-1:0]    owner, owner_next, owner_inc;
   logic [IDX_W-1:0]    rr_ptr, rr_next;
   logic [NUM_MANAGERS-1:0] req, req_others, owner_oh;
   logic [IDX_W:0]      pick_all, pick_oth;
   logic [31:0]         own_addr, own_wdata;
   logic [3:0]          own_strb;
   logic                own_rd, own_wr;
   logic                in_wait, busy;
   logic                done_rd, done_wr, tmo, done;

   // Returns {found, index} of the first candidate at or after start, wrapping.
   function automatic logic [IDX_W:0] rr_pick(input logic [IDX_W-1:0] start,
                                              input logic [NUM_MANAGERS-1:0] cand);
      logic [IDX_W:0]          res;
      logic [NUM_MANAGERS-1:0] sh;
      int                      idx;
      res = '0;
      for (int i = NUM_MANAGERS - 1; i >= 0; i--) begin
         idx = (int'(start) + i) % NUM_MANAGERS;
         sh  = cand >> idx;
         if (sh[0]) res = {1'b1, IDX_W'(idx)};
      end
      return res;
   endfunction

   assign req        = mgr_read_request | mgr_write_request;
   assign owner_oh   = NUM_MANAGERS'(1) << owner;
   assign req_others = req & ~owner_oh;
   assign owner_inc  = (owner == IDX_W'(NUM_MANAGERS - 1)) ? '0 : owner + IDX_W'(1);
   assign pick_all   = rr_pick(rr_ptr, req);
   assign pick_oth   = rr_pick(owner_inc, req_others);

   always_comb begin
      own_addr  = '0;
      own_wdata = '0;
      own_strb  = '0;
      own_rd    = 1'b0;
      own_wr    = 1'b0;
      for (int i = 0; i < NUM_MANAGERS; i++) begin
         if (owner == IDX_W'(i)) begin
            own_addr  = mgr_rw_address[i*32 +: 32];
            own_wdata = mgr_write_data[i*32 +: 32];
            own_strb  = mgr_write_strobe[i*4 +: 4];
            own_rd    = mgr_read_request[i];
            own_wr    = mgr_write_request[i];
         end
      end
   end

   assign in_wait = (state == ST_WAIT);
   assign busy    = !reset && (state != ST_IDLE);
   assign done_rd = in_wait && own_rd && bus_read_response;
   assign done_wr = in_wait && own_wr && bus_write_response;
   assign done    = done_rd || done_wr || tmo;

`ifdef RVSTEEL_BUS_ARBITER_TIMEOUT_EN
   logic [31:0] tmo_cnt;

   // Down-counter loaded while in ISSUE so it is fresh on the first WAIT cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (state == ST_ISSUE) begin
         tmo_cnt <= 32'(TIMEOUT_CYCLES);
      end else if (in_wait && !done && (tmo_cnt != '0)) begin
         tmo_cnt <= tmo_cnt - 32'd1;
      end
   end

   assign tmo         = in_wait && (tmo_cnt == '0) && !done_rd && !done_wr;
   assign bus_timeout = busy && tmo;
`else
   assign tmo = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= ST_IDLE;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_next;
         owner  <= owner_next;
         rr_ptr <= rr_next;
      end
   end

   always_comb begin
      state_next = state;
      owner_next = owner;
      rr_next    = rr_ptr;
      case (state)
         ST_IDLE: begin
            if (pick_all[IDX_W]) begin
               owner_next = pick_all[IDX_W-1:0];
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (done) begin
               rr_next = owner_inc;
               if (pick_oth[IDX_W]) begin
                  owner_next = pick_oth[IDX_W-1:0];
                  state_next = ST_ISSUE;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Gating on reset keeps every output quiet for the whole reset window.
   always_comb begin
      grant              = '0;
      bus_rw_address     = '0;
      bus_write_data     = '0;
      bus_write_strobe   = '0;
      bus_read_request   = 1'b0;
      bus_write_request  = 1'b0;
      mgr_read_response  = '0;
      mgr_write_response = '0;
      mgr_read_data      = '0;
      if (busy) begin
         grant             = owner_oh;
         bus_rw_address    = own_addr;
         bus_write_data    = own_wdata;
         bus_write_strobe  = own_strb;
         bus_read_request  = own_rd && !tmo;
         bus_write_request = own_wr && !tmo;
         if (done_rd || (tmo && own_rd)) mgr_read_response  = owner_oh;
         if (done_wr || (tmo && own_wr)) mgr_write_response = owner_oh;
         for (int i = 0; i < NUM_MANAGERS; i++) begin
            if (done_rd && (owner == IDX_W'(i))) mgr_read_data[i*32 +: 32] = bus_read_data;
         end
      end
   end

endmodule

// File: doc/rvsteel_bus_arbiter.md
Name: rvsteel_bus_arbiter

Overview:
- Shares the single manager port of the system bus among NUM_MANAGERS requesters (e.g. processor core, DMA engine, debug module).
- Uses round-robin arbitration, one outstanding transaction at a time.
- Forwards the granted manager's request, routes the bus response back only to that manager, and holds ownership until the transaction completes.
- Sits between the managers and the bus interconnect's manager interface.

Parameters:
- NUM_MANAGERS, 2, number of requesting managers (1..8).
- TIMEOUT_CYCLES, 255, WAIT-state cycles before abort; used only with the optional feature.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- mgr_rw_address  in  NUM_MANAGERS*32  per-manager address; slice i = bits [i*32 +: 32].
- mgr_read_data  out  NUM_MANAGERS*32  read data, returned in the owner's slice only.
- mgr_read_request  in  NUM_MANAGERS  per-manager read request.
- mgr_read_response  out  NUM_MANAGERS  per-manager read response.
- mgr_write_data  in  NUM_MANAGERS*32  per-manager write data.
- mgr_write_strobe  in  NUM_MANAGERS*4  per-manager byte strobes.
- mgr_write_request  in  NUM_MANAGERS  per-manager write request.
- mgr_write_response  out  NUM_MANAGERS  per-manager write response.
- bus_rw_address  out  32  to the interconnect manager port.
- bus_read_data  in  32  from the interconnect.
- bus_read_request  out  1  to the interconnect.
- bus_read_response  in  1  from the interconnect.
- bus_write_data  out  32  to the interconnect.
- bus_write_strobe  out  4  to the interconnect.
- bus_write_request  out  1  to the interconnect.
- bus_write_response  in  1  from the interconnect.
- grant  out  NUM_MANAGERS  one-hot current owner; all zero when IDLE.

Behaviour:
- Manager contract: hold request, address, data and strobe stable until the matching response is sampled high. Read and write are never requested simultaneously by one manager.
- FSM states: IDLE, ISSUE, WAIT.
- The interconnect's response is valid from the second cycle of a request. Its response during the first cycle reflects the previous transaction or the default and must be ignored.
- IDLE:
  - Bus outputs are all zero; grant is zero.
  - If any manager has a request, select the first requester at or after rr_ptr (wrap modulo NUM_MANAGERS).
  - Register the owner; next state is ISSUE.
- ISSUE:
  - Forward the owner's address, data, strobe and requests to the bus.
  - Ignore bus responses; all mgr responses are 0.
  - Next state is WAIT.
- WAIT:
  - Keep forwarding the owner's signals.
  - When bus_read_response (for a read) or bus_write_response (for a write) is 1, pass it combinationally to the owner's response bit. mgr_read_data[owner] = bus_read_data; all other slices are 0.
  - In that completion cycle, set rr_ptr <= owner+1 (mod N) and re-arbitrate among requests excluding the owner:
    - If a winner exists, it becomes the owner and the next state is ISSUE (back-to-back, no idle cycle).
    - Otherwise the next state is IDLE.
  - If the bus response is 0, remain in WAIT (device wait states).
- Non-owner managers always see response 0 and read_data 0.
- Unmapped address: the interconnect returns response 1 with data 0. The transaction completes normally in the first WAIT cycle.
- Throughput: minimum 2 cycles per transaction when requests are back-to-back. A lone request sees its response 3 cycles after assertion (IDLE, ISSUE, WAIT).
- Simultaneous requests in IDLE: the rr_ptr rule decides. After reset rr_ptr=0, so manager 0 wins ties.
- Owner drops its request before completing (protocol violation): the arbiter stays in WAIT until a response or reset. No recovery is provided.
- Reset, including mid-transaction:
  - state=IDLE, rr_ptr=0, grant=0.
  - All bus outputs and mgr responses are 0 in the cycle after reset is sampled and throughout reset.
  - The interrupted transaction is discarded.
- NUM_MANAGERS=1 degenerates to a pass-through with the same ISSUE/WAIT latency.

Optional Feature:
- Macro: RVSTEEL_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - An 8..32-bit counter clears on entry to WAIT and increments each WAIT cycle without a response.
  - When it reaches TIMEOUT_CYCLES, the owner receives response=1 for its request type with read_data 0.
  - Bus requests drop that same cycle, and the 1-bit output bus_timeout pulses high for one cycle.
  - Arbitration then proceeds exactly as on a normal completion.
- Undefined: no counter, no bus_timeout port; WAIT may last indefinitely.

Test Plan:
- Single read, mgr 0, address 0x00000010; device returns 0xCAFEBABE with a 1-cycle response -> mgr_read_response[0]=1 and mgr_read_data[0 slice]=0xCAFEBABE exactly 3 cycles after request; mgr 1 sees 0s; grant=01 during ISSUE/WAIT.
- Both managers request writes in the same cycle after reset -> mgr 0 is served first, mgr 1 immediately next (ISSUE in the completion cycle +1); strobes 0xF and 0x3 appear on bus_write_strobe in order.
- Continuous requests from both managers for 8 transactions -> grant alternates 01,10,01,…; each manager gets exactly 4 completions.
- Device inserts 5 wait cycles (response 0) -> arbiter holds WAIT, bus signals stable, mgr 1's pending request is not granted until mgr 0 completes.
- Reset asserted during WAIT -> next cycle grant=0, bus_read_request=0, all responses 0; after release a fresh request from mgr 1 completes normally.
- With RVSTEEL_BUS_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=4, device never responds -> after 4 WAIT cycles the owner receives response=1 with data 0, bus_timeout pulses once, and the next requester is granted.
